usart_packet_tx: RTL and testbench

- Transmit end of the USART packet link. Consumes one MSG_LENGTH-bit message through the tx_writer valid/ready handshake that the manager drives.
- Serialises the message as NB_BYTES asynchronous byte frames on a single line: start bit, 8 data bits LSB first, optional even parity bit, stop bit.
- Sits between the manager's tx side and the DAQ TX pin. Is the counterpart of the receiver that reports parity_error.

---
 rtl/usart_packet_tx_pkg.sv | 22 ++
 rtl/usart_packet_tx_if.sv | 13 +
 rtl/usart_packet_tx_bit_timer.sv | 33 +++
 rtl/usart_packet_tx.sv | 149 ++++++++++++++
 tb/tb_usart_packet_tx.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usart_packet_tx_pkg.sv
// Shared USART definitions: line levels, tx state encoding and frame length.
// Build option USART_TX_PARITY_EN adds an even-parity bit to every byte frame.
package usart_pkg;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   BYTE_WIDTH = 8;

`ifdef USART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
  localparam int FRAME_BITS = 10;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

  function automatic logic even_parity(input logic [BYTE_WIDTH-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/usart_packet_tx_if.sv
// Message handshake between the link manager (master) and the packet transmitter (slave).
interface usart_packet_tx_if #(
  parameter int MSG_LENGTH = 48
) ();

  logic [MSG_LENGTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/usart_packet_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared with the receive side, which restarts it on the start-bit edge.
module usart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("usart_bit_timer: CLKS_PER_BIT must be at least 2");
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bit_tick = (count_q == LAST);

endmodule

// File: rtl/usart_packet_tx.sv
// USART packet transmitter: sends a MSG_LENGTH-bit message as MSB-first byte frames.
// Define USART_TX_PARITY_EN to insert an even-parity bit after each byte's data bits.
module usart_packet_tx
  import usart_pkg::*;
#(
  parameter int MSG_LENGTH   = 48,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rsnt,
  usart_packet_tx_if.slave tx_if,
  output logic            tx_serial,
  output logic            frame_done
);

  localparam int NB_BYTES = MSG_LENGTH / BYTE_WIDTH;
  localparam int BCW      = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB_BYTES - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(BYTE_WIDTH - 1);

  if ((MSG_LENGTH % BYTE_WIDTH) != 0 || MSG_LENGTH < BYTE_WIDTH) begin : g_bad_len
    $error("usart_packet_tx: MSG_LENGTH must be a non-zero multiple of 8");
  end

  tx_state_e             state_q, state_n;
  logic [MSG_LENGTH-1:0] msg_q;
  logic [2:0]            bit_q, bit_n;
  logic [BCW-1:0]        byte_q, byte_n;
  logic                  ready_q, ready_n;
  logic                  serial_n, done_n;
  logic                  load, shift;
  logic                  bit_tick;
  logic [BYTE_WIDTH-1:0] cur_byte;

  // The byte on the wire is always the top byte; the message shifts left per byte.
  assign cur_byte       = msg_q[MSG_LENGTH-1 -: BYTE_WIDTH];
  assign tx_if.tx_ready = ready_q;

  usart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rsnt),
    .restart (state_q == IDLE),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rsnt) begin
      state_q    <= IDLE;
      msg_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tx_serial  <= IDLE_LEVEL;
      ready_q    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      bit_q      <= bit_n;
      byte_q     <= byte_n;
      tx_serial  <= serial_n;
      ready_q    <= ready_n;
      frame_done <= done_n;
      if (load) begin
        msg_q <= tx_if.tx_data;
      end else if (shift) begin
        msg_q <= msg_q << BYTE_WIDTH;
      end
    end
  end

  // Next-state logic computes the level of the bit being entered, so the line is registered.
  always_comb begin
    state_n  = state_q;
    serial_n = tx_serial;
    ready_n  = 1'b0;
    done_n   = 1'b0;
    bit_n    = bit_q;
    byte_n   = byte_q;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_q)
      IDLE: begin
        serial_n = IDLE_LEVEL;
        ready_n  = 1'b1;
        if (tx_if.tx_valid && ready_q) begin
          state_n  = START;
          serial_n = START_BIT;
          ready_n  = 1'b0;
          bit_n    = '0;
          byte_n   = '0;
          load     = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_n  = DATA;
          serial_n = cur_byte[0];
          bit_n    = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_q == LAST_BIT) begin
`ifdef USART_TX_PARITY_EN
            state_n  = PARITY;
            serial_n = even_parity(cur_byte);
`else
            state_n  = STOP;
            serial_n = STOP_BIT;
`endif
          end else begin
            bit_n    = bit_q + 3'd1;
            serial_n = cur_byte[bit_n];
          end
        end
      end
`ifdef USART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_n  = STOP;
          serial_n = STOP_BIT;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (byte_q == LAST_BYTE) begin
            state_n  = IDLE;
            serial_n = IDLE_LEVEL;
            ready_n  = 1'b1;
            done_n   = 1'b1;
          end else begin
            state_n  = START;
            serial_n = START_BIT;
            byte_n   = byte_q + 1'b1;
            shift    = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = IDLE_LEVEL;
        ready_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_usart_packet_tx.sv
// Self-checking bench for usart_packet_tx against a frame-level line model.
module tb_usart_packet_tx;

  localparam int MSG_LENGTH = 48;
  localparam int C          = 4;
  localparam int NB         = MSG_LENGTH / 8;
`ifdef USART_TX_PARITY_EN
  localparam int FB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rsnt;
  logic tx_serial;
  logic frame_done;

  usart_packet_tx_if #(.MSG_LENGTH(MSG_LENGTH)) tx_if ();

  usart_packet_tx #(
    .MSG_LENGTH  (MSG_LENGTH),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rsnt      (rsnt),
    .tx_if     (tx_if),
    .tx_serial (tx_serial),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_bits[$];
  bit cap[$];

  // Line model: one entry per line bit, bytes MSB first, data LSB first.
  task automatic build_expected(input logic [MSG_LENGTH-1:0] d);
    logic [7:0] b;
    exp_bits.delete();
    for (int k = NB - 1; k >= 0; k--) begin
      b = d[k*8 +: 8];
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      if (PAR) exp_bits.push_back(^b);
      exp_bits.push_back(1'b1);
    end
  endtask

  function automatic int line_errors(output int first_idx);
    int e = 0;
    int n;
    first_idx = -1;
    n = (cap.size() < exp_bits.size() * C) ? cap.size() : exp_bits.size() * C;
    for (int i = 0; i < n; i++) begin
      if (cap[i] != exp_bits[i / C]) begin
        if (first_idx < 0) first_idx = i;
        e++;
      end
    end
    return e;
  endfunction

  function automatic logic [10:0] frame_at(input int f);
    logic [10:0] v = '0;
    for (int k = 0; k < FB; k++) v[k] = cap[(f * FB + k) * C + C / 2];
    return v;
  endfunction

  // Drives one message and records the line while tx_ready is low.
  task automatic capture(input logic [MSG_LENGTH-1:0] d, input bit hold, input bit change,
                         input logic [MSG_LENGTH-1:0] d2, output int wait_cyc, output int low_cyc,
                         output int done_low, output logic done_rise, output logic idle_serial,
                         output bit tmo);
    cap.delete();
    wait_cyc = 0; low_cyc = 0; done_low = 0; tmo = 1'b0; done_rise = 1'b0; idle_serial = 1'b0;
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (tx_if.tx_ready !== 1'b0 && wait_cyc < 20);
    if (tx_if.tx_ready !== 1'b0) begin
      tmo = 1'b1;
      tx_if.tx_valid = 1'b0;
      return;
    end
    if (!hold) tx_if.tx_valid = 1'b0;
    while (tx_if.tx_ready === 1'b0 && low_cyc < 2000) begin
      cap.push_back(tx_serial);
      low_cyc++;
      if (frame_done !== 1'b0) done_low++;
      if (change && low_cyc == 50) tx_if.tx_data = d2;
      @(negedge clk);
    end
    if (tx_if.tx_ready !== 1'b1) begin
      tmo = 1'b1;
      return;
    end
    done_rise   = frame_done;
    idle_serial = tx_serial;
  endtask

  task automatic test_reset();
    rsnt = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({tx_serial, tx_if.tx_ready, frame_done} !== 3'b110) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: serial/ready/done got %b want 110", i,
                 {tx_serial, tx_if.tx_ready, frame_done});
      end
    end
    rsnt = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({tx_serial, tx_if.tx_ready, frame_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_release: serial/ready/done got %b want 110",
               {tx_serial, tx_if.tx_ready, frame_done});
    end
  endtask

  task automatic test_spec_vector();
    int w, lc, dl, fi, e;
    logic dr, is;
    bit tmo;
    logic [10:0] first_exp, last_exp, got;
    first_exp = PAR ? 11'b110_0000_0010 : 11'b010_0000_0010;
    last_exp  = PAR ? 11'b101_0100_1010 : 11'b011_0100_1010;
    build_expected(48'h0102_0304_05A5);
    capture(48'h0102_0304_05A5, 1'b0, 1'b0, '0, w, lc, dl, dr, is, tmo);
    n_cmp++;
    if (tmo) begin n_fail++; $display("FAIL spec_timeout: handshake did not complete"); end
    n_cmp++;
    if (lc != NB * FB * C) begin
      n_fail++; $display("FAIL spec_ready_low: got %0d cycles want %0d", lc, NB * FB * C);
    end
    n_cmp++;
    if (dr !== 1'b1 || dl != 0) begin
      n_fail++; $display("FAIL spec_frame_done: at_rise %b during_frame %0d want 1/0", dr, dl);
    end
    n_cmp++;
    if (is !== 1'b1) begin n_fail++; $display("FAIL spec_idle_line: got %b want 1", is); end
    got = frame_at(0);
    n_cmp++;
    if (got !== first_exp) begin
      n_fail++; $display("FAIL spec_first_frame: got %b want %b", got, first_exp);
    end
    got = frame_at(NB - 1);
    n_cmp++;
    if (got !== last_exp) begin
      n_fail++; $display("FAIL spec_last_frame: got %b want %b", got, last_exp);
    end
    e = line_errors(fi);
    n_cmp++;
    if (e != 0) begin
      n_fail++; $display("FAIL spec_line: %0d bad cycles, first at %0d", e, fi);
    end
  endtask

  task automatic test_random();
    int w, lc, dl, fi, e;
    logic dr, is;
    bit tmo;
    logic [MSG_LENGTH-1:0] d;
    for (int m = 0; m < 4; m++) begin
      d = {$urandom(), 16'($urandom())};
      build_expected(d);
      capture(d, 1'b0, 1'b0, '0, w, lc, dl, dr, is, tmo);
      e = line_errors(fi);
      n_cmp++;
      if (tmo || lc != NB * FB * C || e != 0 || dr !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d] data %h: tmo %0d low %0d (want %0d) bad %0d first %0d done %b",
                 m, d, tmo, lc, NB * FB * C, e, fi, dr);
      end
    end
  endtask

  task automatic test_zero();
    int w, lc, dl, fi, e, highs;
    logic dr, is;
    bit tmo;
    build_expected('0);
    capture('0, 1'b0, 1'b0, '0, w, lc, dl, dr, is, tmo);
    e = line_errors(fi);
    n_cmp++;
    if (tmo || e != 0 || lc != NB * FB * C) begin
      n_fail++; $display("FAIL zero_line: tmo %0d bad %0d first %0d low %0d", tmo, e, fi, lc);
    end
    highs = 0;
    foreach (cap[i]) if (cap[i]) highs++;
    n_cmp++;
    if (highs != NB * C) begin
      n_fail++; $display("FAIL zero_high_cycles: got %0d want %0d", highs, NB * C);
    end
  endtask

  task automatic test_back_to_back();
    int w, lc, dl, fi, e;
    logic dr, is;
    bit tmo;
    logic [MSG_LENGTH-1:0] d1;
    d1 = {$urandom(), 16'($urandom())};
    build_expected(d1);
    capture(d1, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF, w, lc, dl, dr, is, tmo);
    e = line_errors(fi);
    n_cmp++;
    if (tmo || e != 0 || lc != NB * FB * C || dr !== 1'b1 || is !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: tmo %0d bad %0d first %0d low %0d done %b idle %b",
               tmo, e, fi, lc, dr, is);
    end
    build_expected(48'hFFFF_FFFF_FFFF);
    capture(48'hFFFF_FFFF_FFFF, 1'b0, 1'b0, '0, w, lc, dl, dr, is, tmo);
    n_cmp++;
    if (w != 1) begin
      n_fail++; $display("FAIL b2b_gap: idle cycles got %0d want 1", w);
    end
    e = line_errors(fi);
    n_cmp++;
    if (tmo || e != 0 || lc != NB * FB * C) begin
      n_fail++; $display("FAIL b2b_second: tmo %0d bad %0d first %0d low %0d", tmo, e, fi, lc);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w, lc, dl, fi, e, bad, n;
    logic dr, is;
    bit tmo;
    logic [MSG_LENGTH-1:0] d;
    d = {$urandom(), 16'($urandom())};
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_if.tx_ready !== 1'b0 && n < 20);
    tx_if.tx_valid = 1'b0;
    n_cmp++;
    if (tx_if.tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_accept: tx_ready got %b want 0", tx_if.tx_ready);
    end
    // Land inside the data bits of the third byte.
    repeat ((2 * FB + 1 + 3) * C) @(negedge clk);
    rsnt = 1'b1;
    @(negedge clk);
    rsnt = 1'b0;
    n_cmp++;
    if ({tx_serial, tx_if.tx_ready, frame_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL abort_reset: serial/ready/done got %b want 110",
               {tx_serial, tx_if.tx_ready, frame_done});
    end
    bad = 0;
    for (int i = 0; i < 2 * FB * C; i++) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_if.tx_ready !== 1'b1 || frame_done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL abort_quiet: %0d active cycles after reset want 0", bad);
    end
    d = {$urandom(), 16'($urandom())};
    build_expected(d);
    capture(d, 1'b0, 1'b0, '0, w, lc, dl, dr, is, tmo);
    e = line_errors(fi);
    n_cmp++;
    if (tmo || e != 0 || lc != NB * FB * C || dr !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_resend: tmo %0d bad %0d first %0d low %0d done %b", tmo, e, fi, lc, dr);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_random();
    test_zero();
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
